// File: rtl/neureka_tcdm_responder_pkg.sv
// Shared types and constants for the NEUREKA TCDM responder slice.
package neureka_package;

  localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT      = 288;
  localparam int unsigned NEUREKA_RESP_FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned NEUREKA_MEM_LATENCY_MAX         = 2;

  typedef struct packed {
    logic valid;
    logic is_write;
    logic opc;
  } resp_tag_t;

endpackage

// File: rtl/neureka_resp_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible on data_o
// in the same cycle. Simultaneous push and pop on a full FIFO is allowed.
module neureka_resp_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             data_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bypass, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign valid_o = ~empty_o | push_i;
  assign data_o  = empty_o ? data_i : mem_q[rd_ptr_q];

  // An entry arriving into an empty FIFO and popped at once never gets stored.
  assign bypass  = empty_o & push_i & pop_i;
  assign do_push = push_i & ~bypass;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/neureka_tcdm_responder.sv
// TCDM slave responder driving a fixed-latency SRAM with credit-based grant and in-order
// responses. Optional out-of-range detection: NEUREKA_TCDM_RESP_BOUNDS_CHECK_EN.
module neureka_tcdm_responder
  import neureka_package::*;
#(
  parameter int unsigned DW              = NEUREKA_MEM_BANDWIDTH_EXT,
  parameter int unsigned AW              = 32,
  parameter int unsigned NB_WORDS        = 1024,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned RESP_FIFO_DEPTH = NEUREKA_RESP_FIFO_DEPTH_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [AW-1:0]               add_i,
  input  logic                        wen_i,
  input  logic [DW/8-1:0]             be_i,
  input  logic [DW-1:0]               data_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [DW-1:0]               r_data_o,
  output logic                        r_opc_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(NB_WORDS)-1:0] mem_addr_o,
  output logic [DW/8-1:0]             mem_be_o,
  output logic [DW-1:0]               mem_wdata_o,
  input  logic [DW-1:0]               mem_rdata_i
);

  localparam int unsigned OffW  = $clog2(DW / 8);
  localparam int unsigned IdxW  = $clog2(NB_WORDS);
  localparam int unsigned CntW  = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int unsigned FifoW = DW + 1;

  logic [CntW-1:0]  out_cnt_q, out_cnt_d;
  resp_tag_t        tag_q [MEM_LATENCY];
  resp_tag_t        tag_d [MEM_LATENCY];
  resp_tag_t        tag_exit;
  logic             oob, gnt, push, pop;
  logic [FifoW-1:0] push_data, fifo_data;
  logic             fifo_valid, fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic             unused_sig;

`ifdef NEUREKA_TCDM_RESP_BOUNDS_CHECK_EN
  localparam logic [AW:0] MemBytes = (AW + 1)'(NB_WORDS * (DW / 8));
  assign oob = ({1'b0, add_i} >= MemBytes);
`else
  assign oob = 1'b0;
`endif

  // Credits cover pipeline plus FIFO, so the never-stalling pipeline cannot overflow the FIFO.
  assign gnt         = req_i & ~clear_i & (out_cnt_q < CntW'(RESP_FIFO_DEPTH));
  assign gnt_o       = gnt;
  assign mem_req_o   = gnt & ~oob;
  assign mem_we_o    = ~wen_i;
  assign mem_addr_o  = add_i[OffW +: IdxW];
  assign mem_be_o    = be_i;
  assign mem_wdata_o = data_i;

  assign pop = fifo_valid & r_ready_i;

  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({gnt, pop})
      2'b10:   out_cnt_d = out_cnt_q + CntW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CntW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    if (clear_i) begin
      out_cnt_d = '0;
    end
  end

  always_comb begin
    tag_d[0] = '{valid: gnt, is_write: ~wen_i, opc: oob};
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (clear_i) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        tag_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      out_cnt_q <= out_cnt_d;
      tag_q     <= tag_d;
    end
  end

  assign tag_exit  = tag_q[MEM_LATENCY-1];
  assign push      = tag_exit.valid;
  // Writes and rejected accesses return zero data regardless of what the SRAM drives.
  assign push_data = {tag_exit.opc,
                      (tag_exit.is_write | tag_exit.opc) ? {DW{1'b0}} : mem_rdata_i};

  neureka_resp_fifo #(
    .Width (FifoW),
    .Depth (RESP_FIFO_DEPTH)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign r_valid_o = fifo_valid;
  assign r_data_o  = fifo_valid ? fifo_data[DW-1:0] : '0;
  assign r_opc_o   = fifo_valid & fifo_data[DW];

  assign unused_sig = ^{add_i, fifo_full, fifo_empty, fifo_count};

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Self-checking bench for neureka_tcdm_responder: directed steps plus a random phase checked
// against a queue-based response model and a byte-level memory image.
module tb_neureka_tcdm_responder;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned NBW   = 1024;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned MEMB  = NBW * BYTES;

  logic                   clk;
  logic                   rst_ni, clear_i, req_i, gnt_o, wen_i, r_valid_o, r_ready_i, r_opc_o;
  logic [AW-1:0]          add_i;
  logic [BYTES-1:0]       be_i, mem_be_o;
  logic [DW-1:0]          data_i, r_data_o, mem_wdata_o, mem_rdata_i;
  logic                   mem_req_o, mem_we_o;
  logic [$clog2(NBW)-1:0] mem_addr_o;

  neureka_tcdm_responder #(
    .DW              (DW),
    .AW              (AW),
    .NB_WORDS        (NBW),
    .MEM_LATENCY     (LAT),
    .RESP_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .be_i        (be_i),
    .data_i      (data_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_data_o    (r_data_o),
    .r_opc_o     (r_opc_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro with LAT-cycle read latency
  logic [DW-1:0] sram    [NBW];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < NBW; i++) sram[i] <= '0;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BYTES; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        rd_pipe[0] <= sram[mem_addr_o];
      end
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = rd_pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          opc;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NBW];
  int            cyc, checks, errors, n_gnt;
  logic          last_gnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge against the model, then advance to just after posedge.
  task automatic cycle();
    logic        ev, eg, oob_e;
    int unsigned w;
    exp_t        e;
    @(negedge clk);
    last_gnt = gnt_o;
    if (gnt_o) n_gnt++;
    ev = 1'b0;
    if (rst_ni) begin
      if (!clear_i) begin
        ev = (exp_q.size() != 0) && (cyc >= exp_q[0].cyc + int'(LAT));
        chk("r_valid", r_valid_o, ev);
        if (ev) begin
          chk("r_data", r_data_o, exp_q[0].data);
          chk("r_opc", r_opc_o, exp_q[0].opc);
        end
      end
      eg = req_i && !clear_i && (exp_q.size() < DEPTH);
      chk("gnt", gnt_o, eg);
      if (eg) begin
        oob_e = 1'b0;
`ifdef NEUREKA_TCDM_RESP_BOUNDS_CHECK_EN
        oob_e = (add_i >= MEMB);
`endif
        w = (add_i / BYTES) % NBW;
        chk("mem_req", mem_req_o, !oob_e);
        if (!oob_e) begin
          chk("mem_addr", mem_addr_o, w);
          chk("mem_we", mem_we_o, !wen_i);
          chk("mem_wdata", mem_wdata_o, data_i);
        end
        e.cyc  = cyc;
        e.opc  = oob_e;
        e.data = (wen_i && !oob_e) ? ref_mem[w] : '0;
        if (!wen_i && !oob_e)
          for (int b = 0; b < BYTES; b++)
            if (be_i[b]) ref_mem[w][8*b +: 8] = data_i[8*b +: 8];
        exp_q.push_back(e);
      end else begin
        chk("mem_req_idle", mem_req_o, 1'b0);
      end
      if (ev && r_ready_i && !clear_i) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    if (clear_i || !rst_ni) exp_q.delete();
  endtask

  task automatic drive(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BYTES-1:0] be);
    req_i  = 1'b1;
    wen_i  = rd;
    add_i  = a;
    data_i = d;
    be_i   = be;
    cycle();
    req_i  = 1'b0;
  endtask

  task automatic drain();
    req_i     = 1'b0;
    r_ready_i = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle();
    chk("drain_empty", exp_q.size(), 0);
    cycle();
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] w1, w2;
    int            g0;
    checks = 0; errors = 0; cyc = 0; n_gnt = 0; last_gnt = 1'b0;
    rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b0; wen_i = 1'b1;
    add_i = '0; be_i = '0; data_i = '0; r_ready_i = 1'b0;
    for (int i = 0; i < NBW; i++) ref_mem[i] = '0;

    repeat (3) cycle();
    chk("rst_r_valid", r_valid_o, 1'b0);
    chk("rst_r_data", r_data_o, '0);
    chk("rst_r_opc", r_opc_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    rst_ni = 1'b1;

    // Single read
    r_ready_i = 1'b1;
    drive(1'b0, 32'h40, {BYTES{8'hA5}}, '1);
    drive(1'b1, 32'h40, rnd64(), '0);
    repeat (LAT - 1) cycle();
    chk("single_rd_valid", r_valid_o, 1'b1);
    chk("single_rd_data", r_data_o, {BYTES{8'hA5}});
    drain();

    // Partial write on word 3
    w1 = rnd64();
    w2 = rnd64();
    drive(1'b0, 32'(3 * BYTES), w1, '1);
    drive(1'b0, 32'(3 * BYTES), w2, 8'h0F);
    chk("wr_resp_valid", r_valid_o, 1'b1);
    chk("wr_resp_data", r_data_o, '0);
    drive(1'b1, 32'(3 * BYTES), '0, '0);
    chk("partial_rd", r_data_o, {w1[63:32], w2[31:0]});
    drain();

    // Back-to-back streaming
    g0 = n_gnt;
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom_range(MEMB - 1), rnd64(), '0);
    chk("stream_grants", n_gnt - g0, 16);
    drain();

    // Backpressure
    r_ready_i = 1'b0;
    req_i     = 1'b1;
    wen_i     = 1'b1;
    g0        = n_gnt;
    for (int i = 0; i < 8; i++) begin
      add_i = $urandom_range(MEMB - 1);
      cycle();
    end
    chk("bp_grants", n_gnt - g0, DEPTH);
    r_ready_i = 1'b1;
    cycle();
    chk("bp_gnt_at_pop", last_gnt, 1'b0);
    cycle();
    chk("bp_gnt_after_pop", last_gnt, 1'b1);
    drain();

    // Clear with three pending responses
    r_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom_range(MEMB - 1), '0, '0);
    clear_i = 1'b1;
    req_i   = 1'b1;
    cycle();
    clear_i = 1'b0;
    req_i   = 1'b0;
    chk("clear_r_valid", r_valid_o, 1'b0);
    r_ready_i = 1'b1;
    drive(1'b1, 32'h40, '0, '0);
    drain();

    // Address just past the end of memory
    drive(1'b1, MEMB, '0, '0);
`ifdef NEUREKA_TCDM_RESP_BOUNDS_CHECK_EN
    chk("oob_opc", r_opc_o, 1'b1);
    chk("oob_data", r_data_o, '0);
`else
    chk("wrap_opc", r_opc_o, 1'b0);
    chk("wrap_data", r_data_o, ref_mem[0]);
`endif
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_i     = ($urandom_range(3) != 0);
      wen_i     = $urandom_range(1);
      add_i     = ($urandom_range(7) == 0) ? MEMB + $urandom_range(MEMB - 1)
                                           : $urandom_range(MEMB - 1);
      be_i      = BYTES'($urandom);
      data_i    = rnd64();
      r_ready_i = ($urandom_range(3) != 0);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neureka_tcdm_responder.md
Name: neureka_tcdm_responder

Overview:
- TCDM slave-side responder: the far end of the streamer's master ports (feature/weight TCDM, dedicated weight-memory port).
- Accepts HCI core requests (req/gnt, add, wen, be, data) and drives a single-port SRAM macro with a configurable fixed read latency.
- Returns in-order responses (r_valid/r_ready, r_data, r_opc) through a small fall-through response FIFO, using credit-based grant so backpressure never loses data.
- Returns a response for writes as well; the master-side r_valid filter discards write responses.

Parameters:
- DW, NEUREKA_MEM_BANDWIDTH_EXT, data width in bits (multiple of 32).
- AW, 32, request address width (byte address).
- NB_WORDS, 1024, SRAM depth in DW-bit words (power of 2).
- MEM_LATENCY, 1, SRAM read latency in cycles (legal values 1 and 2).
- RESP_FIFO_DEPTH, 4, response FIFO entries and credit limit (must be >= MEM_LATENCY+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous soft clear.
- req_i  in  1  request valid.
- gnt_o  out  1  request grant.
- add_i  in  AW  byte address.
- wen_i  in  1  1 = read, 0 = write (HCI convention).
- be_i  in  DW/8  byte enables (writes).
- data_i  in  DW  write data.
- r_valid_o  out  1  response valid.
- r_ready_i  in  1  response ready.
- r_data_o  out  DW  read data (0 for writes).
- r_opc_o  out  1  error flag.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  log2(NB_WORDS)  word index.
- mem_be_o  out  DW/8  SRAM byte enables.
- mem_wdata_o  out  DW  SRAM write data.
- mem_rdata_i  in  DW  SRAM read data, valid MEM_LATENCY cycles after the mem_req_o read.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_ni is synchronous and active-low. All state (counter, tag pipeline, FIFO) is updated on the rising edge of clk_i.
- Reset values: credit counter = 0, pipeline empty, FIFO empty, r_valid_o = 0, r_data_o = 0, r_opc_o = 0, mem_req_o = 0.
- clear_i: same effect as reset on the next edge. In-flight responses are dropped. gnt_o and mem_req_o are forced to 0 while clear_i is high.
- Credit counter `out_cnt` (0..RESP_FIFO_DEPTH) counts granted requests whose response has not yet been popped.
  - gnt_o = req_i & ~clear_i & (out_cnt < RESP_FIFO_DEPTH), combinational.
  - A grant increments out_cnt; r_valid_o & r_ready_i decrements it; both in the same cycle leave it unchanged.
- Grant cycle: mem_req_o = gnt_o, mem_we_o = ~wen_i, mem_addr_o = add_i[log2(DW/8) +: log2(NB_WORDS)], mem_be_o = be_i, mem_wdata_o = data_i, all combinational from the request.
- Tag pipeline: MEM_LATENCY stages of {valid, is_write, opc}, shifted every cycle. The pipeline never stalls; the credit rule guarantees FIFO space.
- Pipeline exit:
  - An entry is pushed into the response FIFO with data = is_write ? 0 : mem_rdata_i.
  - The FIFO is fall-through: when empty, the exiting entry appears on r_valid_o in the same cycle.
  - Read latency from grant to r_valid_o is exactly MEM_LATENCY cycles when the FIFO is empty and r_ready_i is high.
  - A simultaneous push and pop on a full FIFO is legal.
- Ordering: responses are strictly in grant order. r_data_o and r_opc_o stay stable while r_valid_o & ~r_ready_i.
- Full throughput: with r_ready_i held high, one grant per cycle is sustained indefinitely.
- Backpressure: with r_ready_i low, exactly RESP_FIFO_DEPTH requests are granted, then gnt_o = 0. gnt_o returns in the cycle after the first pop.

Optional Feature:
- Macro: NEUREKA_TCDM_RESP_BOUNDS_CHECK_EN.
- Defined:
  - A request with add_i >= NB_WORDS*DW/8 is granted normally but mem_req_o = 0.
  - Its response carries r_opc_o = 1 and r_data_o = 0.
  - Credits are counted as for any other request.
- Undefined: upper address bits are ignored (address wraps), mem_req_o = gnt_o, and r_opc_o is constantly 0.

Decomposition:
- neureka_package gets `resp_tag_t` {valid, is_write, opc} and the constants NEUREKA_RESP_FIFO_DEPTH_DEFAULT = 4 and NEUREKA_MEM_LATENCY_MAX = 2.
- One sub-module: neureka_resp_fifo, a fall-through FIFO with push/pop/full/empty/count, parameterised by width and depth.
- The responder holds the credit counter, tag pipeline, address slicing and the bounds check.

Test Plan:
- Single read: write 0xA5 (all bytes) to addr 0x40, then read 0x40 with r_ready_i = 1 -> r_valid_o exactly MEM_LATENCY cycles after grant, r_data_o = all 0xA5.
- Back-to-back streaming: 16 consecutive reads, r_ready_i = 1 -> gnt_o high every cycle, 16 responses in order, out_cnt never exceeds MEM_LATENCY.
- Backpressure: r_ready_i = 0, req_i held high -> exactly 4 grants, then gnt_o = 0; raise r_ready_i -> one pop per cycle and gnt_o back high the cycle after the first pop.
- Partial write: be_i = 0x0F on word 3, then read -> only bytes 0..3 updated; the write response has r_valid_o = 1 and r_data_o = 0.
- clear_i with 3 responses pending -> next cycle r_valid_o = 0, out_cnt = 0, FIFO empty; a new read completes normally.
- Bounds (macro defined): read add_i = NB_WORDS*DW/8 -> mem_req_o = 0, response r_opc_o = 1, r_data_o = 0. Macro undefined: same address wraps to word 0 with r_opc_o = 0.
